// File: rtl/rvfi_trace_buffer.sv
// Post-mortem RVFI retirement recorder: circular buffer of the last DEPTH
// retirements, frozen POST_TRIGGER records after a trigger, drained oldest-first.
module rvfi_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int POST_TRIGGER = 4,
  parameter bit STOP_ON_TRAP = 1'b1
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic        force_trig,
  input  logic        arm,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_insn,
  output logic [15:0] rd_order,
  output logic [2:0]  rd_flags,
  output logic [1:0]  state,
  output logic        wrapped,
  output logic [15:0] dropped
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ARMED = 2'b00, POST = 2'b01, FROZEN = 2'b10} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [15:0] order;
    logic [2:0]  flags;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        entry, rd_ent;
  state_t        st, st_nxt;
  logic [AW-1:0] wr_ptr, wr_nxt, rd_ptr, post_cnt, post_nxt;
  logic [AW:0]   count, count_nxt;
  logic          record, trigger, pop;
  logic          unused_order;

  assign unused_order = ^rvfi_order[63:16];
  assign entry   = '{pc: rvfi_pc_rdata, insn: rvfi_insn, order: rvfi_order[15:0],
                     flags: {rvfi_halt, rvfi_intr, rvfi_trap}};
  // arm wins over everything in its cycle, including the retirement
  assign record  = rvfi_valid && (st != FROZEN) && !arm;
  assign trigger = force_trig || (rvfi_valid && (rvfi_halt || (STOP_ON_TRAP && rvfi_trap)));
  assign rd_valid = (st == FROZEN) && (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_ent   = rd_valid ? mem[rd_ptr] : '0;
  assign rd_pc    = rd_ent.pc;
  assign rd_insn  = rd_ent.insn;
  assign rd_order = rd_ent.order;
  assign rd_flags = rd_ent.flags;
  assign state    = st;

  always_comb begin
    st_nxt    = st;
    post_nxt  = post_cnt;
    count_nxt = count;
    wr_nxt    = wr_ptr;
    if (arm) begin
      st_nxt    = ARMED;
      post_nxt  = '0;
      count_nxt = '0;
    end else begin
      case (st)
        ARMED: if (trigger) begin
          post_nxt = AW'(POST_TRIGGER);
          st_nxt   = (POST_TRIGGER == 0) ? FROZEN : POST;
        end
        POST: if (record) begin
          post_nxt = post_cnt - AW'(1);
          if (post_cnt == AW'(1)) st_nxt = FROZEN;
        end
        default: ;
      endcase
      if (record) begin
        wr_nxt = wr_ptr + AW'(1);
        if (count != FULL) count_nxt = count + (AW+1)'(1);
      end else if (pop) begin
        count_nxt = count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      st       <= ARMED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      wrapped  <= 1'b0;
      dropped  <= '0;
    end else begin
      st       <= st_nxt;
      wr_ptr   <= wr_nxt;
      count    <= count_nxt;
      post_cnt <= post_nxt;
      if (arm) begin
        wrapped <= 1'b0;
        dropped <= '0;
      end else begin
        if (record && count == FULL) wrapped <= 1'b1;
        if (st == FROZEN && rvfi_valid && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      end
      // on freeze point at the oldest entry, including this cycle's record
      if (st != FROZEN && st_nxt == FROZEN) rd_ptr <= wr_nxt - count_nxt[AW-1:0];
      else if (pop && !arm)                 rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (record) mem[wr_ptr] <= entry;
  end
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: three configurations driven in parallel and
// compared each cycle against a queue-based reference model.
module tb_rvfi_trace_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [15:0] order;
    logic [2:0]  flags;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rvfi_valid = 0, rvfi_trap = 0, rvfi_halt = 0, rvfi_intr = 0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0, rvfi_pc_rdata = '0;
  logic        force_trig = 0, arm = 0, rd_ready = 0;

  logic        o_rd_valid [3];
  logic [31:0] o_rd_pc    [3];
  logic [31:0] o_rd_insn  [3];
  logic [15:0] o_rd_order [3];
  logic [2:0]  o_rd_flags [3];
  logic [1:0]  o_state    [3];
  logic        o_wrapped  [3];
  logic [15:0] o_dropped  [3];

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(.DEPTH(16), .POST_TRIGGER(4), .STOP_ON_TRAP(1'b1)) dut0 (
    .sys_clock(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .force_trig(force_trig), .arm(arm), .rd_valid(o_rd_valid[0]),
    .rd_ready(rd_ready), .rd_pc(o_rd_pc[0]), .rd_insn(o_rd_insn[0]), .rd_order(o_rd_order[0]),
    .rd_flags(o_rd_flags[0]), .state(o_state[0]), .wrapped(o_wrapped[0]), .dropped(o_dropped[0]));
  rvfi_trace_buffer #(.DEPTH(16), .POST_TRIGGER(0), .STOP_ON_TRAP(1'b1)) dut1 (
    .sys_clock(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .force_trig(force_trig), .arm(arm), .rd_valid(o_rd_valid[1]),
    .rd_ready(rd_ready), .rd_pc(o_rd_pc[1]), .rd_insn(o_rd_insn[1]), .rd_order(o_rd_order[1]),
    .rd_flags(o_rd_flags[1]), .state(o_state[1]), .wrapped(o_wrapped[1]), .dropped(o_dropped[1]));
  rvfi_trace_buffer #(.DEPTH(16), .POST_TRIGGER(4), .STOP_ON_TRAP(1'b0)) dut2 (
    .sys_clock(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .force_trig(force_trig), .arm(arm), .rd_valid(o_rd_valid[2]),
    .rd_ready(rd_ready), .rd_pc(o_rd_pc[2]), .rd_insn(o_rd_insn[2]), .rd_order(o_rd_order[2]),
    .rd_flags(o_rd_flags[2]), .state(o_state[2]), .wrapped(o_wrapped[2]), .dropped(o_dropped[2]));

  // reference model: a bounded queue of the kept retirements per configuration
  ent_t mq [3][$];
  int   m_st [3];
  int   m_pcnt [3];
  bit   m_wrap [3];
  int   m_drop [3];

  function automatic int pt_of(int i);  return (i == 1) ? 0 : 4; endfunction
  function automatic bit sot_of(int i); return (i != 2);         endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete(); m_st[i] = 0; m_pcnt[i] = 0; m_wrap[i] = 0; m_drop[i] = 0;
    end
  endtask

  task automatic model_update();
    ent_t e;
    e = '{pc: rvfi_pc_rdata, insn: rvfi_insn, order: rvfi_order[15:0],
          flags: {rvfi_halt, rvfi_intr, rvfi_trap}};
    for (int i = 0; i < 3; i++) begin
      if (arm) begin
        mq[i].delete(); m_st[i] = 0; m_pcnt[i] = 0; m_wrap[i] = 0; m_drop[i] = 0;
      end else if (m_st[i] == 2) begin
        if (rvfi_valid && m_drop[i] < 65535) m_drop[i]++;
        if (rd_ready && mq[i].size() > 0) void'(mq[i].pop_front());
      end else begin
        if (rvfi_valid) begin
          mq[i].push_back(e);
          if (mq[i].size() > 16) begin void'(mq[i].pop_front()); m_wrap[i] = 1; end
        end
        if (m_st[i] == 0) begin
          if (force_trig || (rvfi_valid && (rvfi_halt || (sot_of(i) && rvfi_trap)))) begin
            m_pcnt[i] = pt_of(i);
            m_st[i]   = (pt_of(i) == 0) ? 2 : 1;
          end
        end else if (rvfi_valid) begin
          m_pcnt[i]--;
          if (m_pcnt[i] == 0) m_st[i] = 2;
        end
      end
    end
  endtask

  function automatic logic [102:0] exp_vec(int i);
    ent_t e; logic rv; logic [1:0] s;
    rv = (m_st[i] == 2) && (mq[i].size() != 0);
    e  = rv ? mq[i][0] : '0;
    s  = m_st[i][1:0];
    return {rv, e, s, m_wrap[i], m_drop[i][15:0]};
  endfunction

  function automatic logic [102:0] obs_vec(int i);
    return {o_rd_valid[i], o_rd_pc[i], o_rd_insn[i], o_rd_order[i], o_rd_flags[i],
            o_state[i], o_wrapped[i], o_dropped[i]};
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rvfi_valid = 0; rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
    force_trig = 0; arm = 0;
  endtask

  task automatic ret(input logic [31:0] pc, input logic [63:0] ord, input logic [2:0] fl);
    rvfi_valid = 1; rvfi_pc_rdata = pc; rvfi_order = ord; rvfi_insn = $urandom;
    {rvfi_halt, rvfi_intr, rvfi_trap} = fl;
    tick();
    clear_in();
  endtask

  task automatic pulse_arm();   arm = 1; tick(); arm = 0;               endtask
  task automatic pulse_force(); force_trig = 1; tick(); force_trig = 0; endtask

  task automatic test_reset();
    reset = 0; clear_in(); rd_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_vec(i) !== exp_vec(i) || obs_vec(i) !== '0)
        $display("FAIL reset inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
      else n_pass++;
    end
    reset = 1;
  endtask

  task automatic test_basic_trigger();
    pulse_arm();
    for (int k = 0; k < 5; k++) ret(32'h100 + 32'(4*k), 64'(k), 3'b000);
    pulse_force();
    for (int k = 5; k < 9; k++) ret(32'h100 + 32'(4*k), 64'(k), 3'b000);
    n_chk++;
    if (o_state[0] !== 2'b10) $display("FAIL basic_frozen got %b want 10", o_state[0]);
    else n_pass++;
    rd_ready = 1;
    for (int k = 0; k < 9; k++) begin
      n_chk++;
      if (o_rd_valid[0] !== 1'b1 || o_rd_pc[0] !== 32'h100 + 32'(4*k) || obs_vec(0) !== exp_vec(0))
        $display("FAIL basic_read%0d got %h want pc %h / %h", k, obs_vec(0), 32'h100 + 32'(4*k), exp_vec(0));
      else n_pass++;
      tick();
    end
    rd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_vec(i) !== exp_vec(i)) $display("FAIL basic_end inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
      else n_pass++;
    end
    n_chk++;
    if (o_rd_valid[0] !== 1'b0) $display("FAIL basic_empty got %b want 0", o_rd_valid[0]);
    else n_pass++;
  endtask

  task automatic test_wrap_trap();
    pulse_arm();
    for (int k = 0; k < 40; k++)
      ret($urandom, {32'($urandom), 16'($urandom), 16'(k)}, (k == 39) ? 3'b001 : 3'b000);
    n_chk++;
    if (o_wrapped[1] !== 1'b1 || o_state[1] !== 2'b10)
      $display("FAIL wrap_flag got wrapped %b state %b want 1 10", o_wrapped[1], o_state[1]);
    else n_pass++;
    rd_ready = 1;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (o_rd_order[1] !== 16'(24 + k) || o_rd_flags[1] !== ((k == 15) ? 3'b001 : 3'b000) ||
          obs_vec(1) !== exp_vec(1))
        $display("FAIL wrap_read%0d got %h want order %0d / %h", k, obs_vec(1), 24 + k, exp_vec(1));
      else n_pass++;
      tick();
    end
    rd_ready = 0;
    n_chk++;
    if (o_rd_valid[1] !== 1'b0 || o_state[1] !== 2'b10)
      $display("FAIL wrap_drained got valid %b state %b want 0 10", o_rd_valid[1], o_state[1]);
    else n_pass++;
  endtask

  task automatic test_stall_dropped();
    logic [31:0] pc0;
    pulse_arm();
    for (int k = 0; k < 6; k++) ret(32'h400 + 32'(4*k), 64'(k), 3'b000);
    pulse_force();
    for (int k = 6; k < 10; k++) ret(32'h400 + 32'(4*k), 64'(k), 3'b000);
    pc0 = 32'h400;
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (o_rd_pc[0] !== pc0 || obs_vec(0) !== exp_vec(0))
        $display("FAIL stall_hold%0d got %h want pc %h", c, obs_vec(0), pc0);
      else n_pass++;
      tick();
    end
    for (int k = 0; k < 3; k++) ret($urandom, 64'($urandom), 3'b000);
    n_chk++;
    if (o_dropped[0] !== 16'd3 || o_rd_pc[0] !== pc0 || obs_vec(0) !== exp_vec(0))
      $display("FAIL stall_dropped got dropped %0d pc %h want 3 %h", o_dropped[0], o_rd_pc[0], pc0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_vec(i) !== exp_vec(i)) $display("FAIL stall_all inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
      else n_pass++;
    end
    rd_ready = 1; tick(); tick(); rd_ready = 0;
    n_chk++;
    if (o_rd_pc[0] !== 32'h408) $display("FAIL stall_pop got %h want 00000408", o_rd_pc[0]);
    else n_pass++;
  endtask

  task automatic test_arm_collision();
    arm = 1; rd_ready = 1;
    rvfi_valid = 1; rvfi_pc_rdata = 32'hDEAD0000; rvfi_order = 64'hAA; rvfi_insn = $urandom;
    tick();
    clear_in(); rd_ready = 0;
    n_chk++;
    if (o_state[0] !== 2'b00 || o_rd_valid[0] !== 1'b0 || o_dropped[0] !== 16'd0 || o_wrapped[0] !== 1'b0)
      $display("FAIL arm_clear got state %b valid %b dropped %0d want 00 0 0", o_state[0], o_rd_valid[0], o_dropped[0]);
    else n_pass++;
    for (int k = 0; k < 2; k++) ret(32'h200 + 32'(4*k), 64'(k), 3'b000);
    pulse_force();
    for (int k = 2; k < 6; k++) ret(32'h200 + 32'(4*k), 64'(k), 3'b000);
    rd_ready = 1;
    for (int k = 0; k < 7; k++) begin
      n_chk++;
      if (o_rd_valid[0] !== (k < 6) || (k < 6 && o_rd_pc[0] !== 32'h200 + 32'(4*k)) || obs_vec(0) !== exp_vec(0))
        $display("FAIL arm_read%0d got %h want %h", k, obs_vec(0), exp_vec(0));
      else n_pass++;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_post_halt_reset();
    pulse_arm();
    for (int k = 0; k < 20; k++) ret($urandom, 64'(k), 3'b000);
    pulse_force();
    ret(32'h300, 64'd100, 3'b100);
    n_chk++;
    if (o_state[0] !== 2'b01) $display("FAIL post_halt got state %b want 01", o_state[0]);
    else n_pass++;
    for (int k = 0; k < 3; k++) ret($urandom, 64'(101 + k), 3'b000);
    n_chk++;
    if (o_state[0] !== 2'b10 || o_wrapped[0] !== 1'b1 || obs_vec(0) !== exp_vec(0))
      $display("FAIL post_frozen got %h want %h", obs_vec(0), exp_vec(0));
    else n_pass++;
    rd_ready = 1; tick(); tick(); rd_ready = 0;
    reset = 0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (o_rd_valid[i] !== 1'b0 || o_state[i] !== 2'b00 || o_wrapped[i] !== 1'b0 || obs_vec(i) !== exp_vec(i))
        $display("FAIL async_reset inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_force_trap();
    pulse_arm();
    ret(32'h500, 64'd0, 3'b000);
    ret(32'h504, 64'd1, 3'b000);
    force_trig = 1;
    ret(32'h508, 64'd2, 3'b001);
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (o_rd_valid[1] !== (k < 3) || (k == 2 && o_rd_flags[1] !== 3'b001) || obs_vec(1) !== exp_vec(1))
        $display("FAIL force_trap_read%0d got %h want %h", k, obs_vec(1), exp_vec(1));
      else n_pass++;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_no_trap_trigger();
    pulse_arm();
    for (int k = 0; k < 5; k++) begin
      ret(32'h600 + 32'(4*k), 64'(k), 3'b001);
      n_chk++;
      if (o_state[2] !== 2'b00) $display("FAIL notrap_armed%0d got %b want 00", k, o_state[2]);
      else n_pass++;
    end
    ret(32'h614, 64'd5, 3'b100);
    n_chk++;
    if (o_state[2] !== 2'b01) $display("FAIL notrap_halt got %b want 01", o_state[2]);
    else n_pass++;
    for (int k = 6; k < 10; k++) ret(32'h600 + 32'(4*k), 64'(k), 3'b000);
    rd_ready = 1;
    for (int k = 0; k < 11; k++) begin
      n_chk++;
      if (o_rd_valid[2] !== (k < 10) || (k < 10 && o_rd_pc[2] !== 32'h600 + 32'(4*k)) || obs_vec(2) !== exp_vec(2))
        $display("FAIL notrap_read%0d got %h want %h", k, obs_vec(2), exp_vec(2));
      else n_pass++;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_random();
    pulse_arm();
    for (int c = 0; c < 400; c++) begin
      rvfi_valid = ($urandom_range(0, 9) < 6);
      rvfi_trap  = ($urandom_range(0, 99) < 3);
      rvfi_halt  = ($urandom_range(0, 99) < 2);
      rvfi_intr  = ($urandom_range(0, 9) == 0);
      force_trig = ($urandom_range(0, 99) < 3);
      arm        = ($urandom_range(0, 99) < 2);
      rd_ready   = $urandom_range(0, 1);
      rvfi_pc_rdata = $urandom; rvfi_insn = $urandom; rvfi_order = {32'($urandom), 32'($urandom)};
      tick();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs_vec(i) !== exp_vec(i))
          $display("FAIL random c%0d inst%0d got %h want %h", c, i, obs_vec(i), exp_vec(i));
        else n_pass++;
      end
    end
    clear_in(); rd_ready = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_trigger();
    test_wrap_trap();
    test_stall_dropped();
    test_arm_collision();
    test_post_halt_reset();
    test_force_trap();
    test_no_trap_trigger();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
